aes32_round_seq: RTL and testbench

//  Multi-cycle sequencer that executes one full AES-128 encrypt round as a series of

---
 rtl/aes_seq_pkg.sv | 76 +++++++
 rtl/aes32_lane.sv | 35 +++
 rtl/aes32_round_seq.sv | 162 ++++++++++++++++
 tb/tb_aes32_round_seq.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared types and AES byte-step helpers for the scalar round sequencer.
// The esi/esmi functions give the rd result of one aes32esi/aes32esmi step.
package aes_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int unsigned NWORDS        = 4;
    localparam int unsigned STEPS_PER_COL = 4;

    // State word feeding byte-step bs of column j (ShiftRows folded into the select).
    function automatic logic [1:0] word_sel(input logic [1:0] j, input logic [1:0] bs);
        return 2'(j + bs);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // S-box as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] rol_bytes(input logic [31:0] x, input logic [1:0] bs);
        logic [31:0] r;
        case (bs)
            2'd0:    r = x;
            2'd1:    r = {x[23:0], x[31:24]};
            2'd2:    r = {x[15:0], x[31:16]};
            default: r = {x[7:0],  x[31:8]};
        endcase
        return r;
    endfunction

    function automatic logic [31:0] aes32esi(input logic [31:0] rs1, input logic [31:0] rs2,
                                             input logic [1:0] bs);
        logic [7:0] so;
        so = sbox(8'(rs2 >> {bs, 3'b000}));
        return rs1 ^ rol_bytes({24'h0, so}, bs);
    endfunction

    function automatic logic [31:0] aes32esmi(input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [1:0] bs);
        logic [7:0] so;
        logic [7:0] so2;
        so  = sbox(8'(rs2 >> {bs, 3'b000}));
        so2 = xtime(so);
        return rs1 ^ rol_bytes({so2 ^ so, so, so, so2}, bs);
    endfunction

endpackage

// File: rtl/aes32_lane.sv
// One column lane: esmi and esi byte-steps, rd select on last-round flag,
// and the accumulator that chains rd back into rs1.
module aes32_lane
    import aes_seq_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [1:0]  i_bs,
    input  logic        i_last,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_key,
    output logic [31:0] o_rd_c
);

    logic [31:0] r_acc;
    logic [31:0] w_rs1;
    logic [31:0] w_rd_mid;
    logic [31:0] w_rd_fin;

    // First step of a column seeds rs1 with the round key word.
    assign w_rs1    = (i_bs == 2'd0) ? i_key : r_acc;
    assign w_rd_mid = aes32esmi(w_rs1, i_rs2, i_bs);
    assign w_rd_fin = aes32esi(w_rs1, i_rs2, i_bs);
    assign o_rd_c   = i_last ? w_rd_fin : w_rd_mid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_rd_c;
        end
    end

endmodule

// File: rtl/aes32_round_seq.sv
// Sequences one AES-128 encrypt round as scalar byte-steps across LANES columns
// and returns the 128-bit next state over a valid/ready handshake.
module aes32_round_seq
    import aes_seq_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_rkey,
    input  logic         in_last,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned STEPS = (NWORDS * STEPS_PER_COL) / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("aes32_round_seq: LANES must be 1, 2 or 4");
    end

    seq_state_e       r_state;
    seq_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_accept;
    logic             w_step_en;
    logic             w_done_step;

    logic [127:0]     r_st;
    logic [127:0]     r_key;
    logic             r_last;
    logic [127:0]     r_res;
    logic [127:0]     w_res_next;
    logic [127:0]     r_out_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [1:0]       w_bs;
    logic [1:0]       w_col [LANES];
    logic [31:0]      w_rs2 [LANES];
    logic [31:0]      w_key [LANES];
    logic [31:0]      w_rd  [LANES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state; flush overrides every state, including an accept in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_step_en    = 1'b0;
        w_done_step  = 1'b0;
        if (flush) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_accept     = 1'b1;
                        w_state_next = RUN;
                        w_cnt_next   = '0;
                    end
                end
                RUN: begin
                    w_step_en = 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        w_done_step  = 1'b1;
                        w_state_next = DONE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    assign w_bs = 2'(r_cnt);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_col[l] = 2'(32'(r_cnt >> 2) * LANES + 32'(l));
        assign w_rs2[l] = r_st[32*word_sel(w_col[l], w_bs) +: 32];
        assign w_key[l] = r_key[32*w_col[l] +: 32];

        aes32_lane u_lane (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_en   (w_step_en),
            .i_bs   (w_bs),
            .i_last (r_last),
            .i_rs2  (w_rs2[l]),
            .i_key  (w_key[l]),
            .o_rd_c (w_rd[l])
        );
    end

    // A column's final byte-step lands its rd in the result word.
    always_comb begin
        w_res_next = r_res;
        if (w_bs == 2'd3) begin
            for (int l = 0; l < LANES; l++) begin
                w_res_next[32*w_col[l] +: 32] = w_rd[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st        <= '0;
            r_key       <= '0;
            r_last      <= 1'b0;
            r_res       <= '0;
            r_out_state <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_st   <= in_state;
                r_key  <= in_rkey;
                r_last <= in_last;
            end
            if (w_step_en) r_res <= w_res_next;
            if (w_done_step) r_out_state <= w_res_next;
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
            r_busy      <= (w_state_next != IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes32_round_seq.sv
// Bench for aes32_round_seq: LANES=1,2,4 instances run concurrently, checked
// against a byte-level AES round model (SubBytes/ShiftRows/MixColumns/AddRoundKey).
module tb_aes32_round_seq;

    localparam int NI    = 3;
    localparam int NJOBS = 1000;

    logic clk = 1'b0;
    logic [NI-1:0] rst;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] in_last;
    logic [NI-1:0] flush;
    logic [NI-1:0] out_ready;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] busy;
    logic [127:0]  in_state  [NI];
    logic [127:0]  in_rkey   [NI];
    logic [127:0]  out_state [NI];

    int checks   = 0;
    int failures = 0;
    logic [7:0] sbox_tbl [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes32_round_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_rkey   (in_rkey[g]),
            .in_last   (in_last[g]),
            .flush     (flush[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        logic [7:0] r;
        r = {a[6:0], 1'b0};
        if (a[7]) r = r ^ 8'h1b;
        return r;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xt(p);
        end
        return acc;
    endfunction

    // S-box by brute-force inverse search plus the FIPS-197 bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_tbl[x] = s;
        end
    endtask

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   mc [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) sb[i] = sbox_tbl[st[8*i +: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                sr[4*c+rr] = sb[4*((c+rr)%4)+rr];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                mc[4*c+rr] = last ? sr[4*c+rr]
                           : xt(sr[4*c+rr]) ^ xt(sr[4*c+(rr+1)%4]) ^ sr[4*c+(rr+1)%4]
                             ^ sr[4*c+(rr+2)%4] ^ sr[4*c+(rr+3)%4];
        for (int i = 0; i < 16; i++) r[8*i +: 8] = mc[i];
        return r ^ key;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int g, input logic [127:0] st, input logic [127:0] key,
                        input logic last);
        int t;
        t = 0;
        while (!in_ready[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check($sformatf("L%0d send_timeout", 1 << g), 128'(in_ready[g]), 128'd1);
        in_state[g] = st;
        in_rkey[g]  = key;
        in_last[g]  = last;
        in_valid[g] = 1'b1;
        @(negedge clk);
        in_valid[g] = 1'b0;
    endtask

    task automatic wait_valid(input int g, output int lat);
        lat = 0;
        while (!out_valid[g] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take(input int g);
        out_ready[g] = 1'b1;
        @(negedge clk);
        out_ready[g] = 1'b0;
    endtask

    task automatic run_all(input int g);
        int           n;
        int           lat;
        int           fc;
        string        p;
        logic [127:0] exp;
        logic [127:0] prev;
        logic [127:0] key;
        logic [127:0] nxt_exp;
        logic [127:0] q [$];
        logic         last;
        bit           stable;
        bit           rose;
        bit           have;
        bit           mbusy;
        bit           acc;
        bit           tak;
        int           mcnt;
        int           sent;
        int           done;
        int           cyc;

        n = 16 >> g;
        p = $sformatf("L%0d", 1 << g);

        check({p, " rst_in_ready"},  128'(in_ready[g]),  128'd1);
        check({p, " rst_out_valid"}, 128'(out_valid[g]), 128'd0);
        check({p, " rst_out_state"}, out_state[g],       128'd0);
        check({p, " rst_busy"},      128'(busy[g]),      128'd0);

        // T1: all-zero middle round
        send(g, 128'd0, 128'd0, 1'b0);
        check({p, " t1_busy"}, 128'(busy[g]), 128'd1);
        check({p, " t1_in_ready_low"}, 128'(in_ready[g]), 128'd0);
        wait_valid(g, lat);
        check({p, " t1_latency"}, 128'(lat), 128'(n));
        check({p, " t1_state"}, out_state[g], {16{8'h63}});
        take(g);
        check({p, " t1_taken"}, 128'(out_valid[g]), 128'd0);
        check({p, " t1_in_ready"}, 128'(in_ready[g]), 128'd1);

        // T2: final round, key XOR onto S-box(0)
        key = 128'h0123456789abcdef_fedcba9876543210;
        send(g, 128'd0, key, 1'b1);
        wait_valid(g, lat);
        check({p, " t2_latency"}, 128'(lat), 128'(n));
        check({p, " t2_state"}, out_state[g], {16{8'h63}} ^ key);
        take(g);

        // T3: backpressure hold in DONE
        key  = rnd128();
        prev = rnd128();
        last = 1'($urandom_range(0, 1));
        exp  = ref_round(prev, key, last);
        send(g, prev, key, last);
        wait_valid(g, lat);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid[g] || out_state[g] !== exp || in_ready[g]) stable = 1'b0;
        end
        check({p, " t3_stable"}, 128'(stable), 128'd1);
        check({p, " t3_state"}, out_state[g], exp);
        take(g);
        check({p, " t3_taken"}, 128'(out_valid[g]), 128'd0);
        check({p, " t3_in_ready"}, 128'(in_ready[g]), 128'd1);
        prev = exp;

        // T4: flush mid-run
        fc = (n > 6) ? 5 : 2;
        send(g, rnd128(), rnd128(), 1'b0);
        repeat (fc) @(negedge clk);
        flush[g] = 1'b1;
        @(negedge clk);
        flush[g] = 1'b0;
        check({p, " t4_busy"}, 128'(busy[g]), 128'd0);
        check({p, " t4_in_ready"}, 128'(in_ready[g]), 128'd1);
        check({p, " t4_out_valid"}, 128'(out_valid[g]), 128'd0);
        check({p, " t4_out_state"}, out_state[g], prev);
        rose = 1'b0;
        repeat (n + 4) begin
            @(negedge clk);
            if (out_valid[g]) rose = 1'b1;
        end
        check({p, " t4_no_valid"}, 128'(rose), 128'd0);

        // flush beats in_valid in IDLE
        in_state[g] = rnd128();
        in_valid[g] = 1'b1;
        flush[g]    = 1'b1;
        @(negedge clk);
        in_valid[g] = 1'b0;
        flush[g]    = 1'b0;
        check({p, " flush_idle_busy"}, 128'(busy[g]), 128'd0);
        check({p, " flush_idle_ready"}, 128'(in_ready[g]), 128'd1);

        send(g, 128'd0, 128'd0, 1'b0);
        wait_valid(g, lat);
        check({p, " t4_next_state"}, out_state[g], {16{8'h63}});
        take(g);

        // T5: async reset at RUN cycle 3
        send(g, rnd128(), rnd128(), 1'b1);
        repeat (3) @(negedge clk);
        #1 rst[g] = 1'b1;
        #1;
        check({p, " t5_out_valid"}, 128'(out_valid[g]), 128'd0);
        check({p, " t5_busy"}, 128'(busy[g]), 128'd0);
        check({p, " t5_in_ready"}, 128'(in_ready[g]), 128'd1);
        check({p, " t5_out_state"}, out_state[g], 128'd0);
        #1 rst[g] = 1'b0;
        @(negedge clk);

        // T6: random back-to-back jobs with random ready
        have  = 1'b0;
        mbusy = 1'b0;
        mcnt  = 0;
        sent  = 0;
        done  = 0;
        cyc   = 0;
        nxt_exp = '0;
        while (done < NJOBS && cyc < 60000) begin
            check({p, " t6_in_ready"}, 128'(in_ready[g]), 128'(!mbusy));
            check({p, " t6_out_valid"}, 128'(out_valid[g]), 128'(mbusy && mcnt >= n));
            if (!have && sent < NJOBS && $urandom_range(0, 3) != 0) begin
                in_state[g] = rnd128();
                in_rkey[g]  = rnd128();
                in_last[g]  = 1'($urandom_range(0, 1));
                nxt_exp     = ref_round(in_state[g], in_rkey[g], in_last[g]);
                have        = 1'b1;
            end
            in_valid[g]  = have;
            out_ready[g] = ($urandom_range(0, 2) != 0);
            acc = have && !mbusy;
            tak = mbusy && mcnt >= n && out_ready[g];
            if (tak) begin
                check({p, " t6_state"}, out_state[g], q.pop_front());
                done++;
            end
            @(negedge clk);
            cyc++;
            if (mbusy) mcnt++;
            if (tak) mbusy = 1'b0;
            if (acc) begin
                q.push_back(nxt_exp);
                have        = 1'b0;
                in_valid[g] = 1'b0;
                mbusy       = 1'b1;
                mcnt        = 0;
                sent++;
            end
        end
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b0;
        check({p, " t6_jobs"}, 128'(done), 128'(NJOBS));
    endtask

    initial begin
        rst       = '1;
        in_valid  = '0;
        in_last   = '0;
        flush     = '0;
        out_ready = '0;
        for (int g = 0; g < NI; g++) begin
            in_state[g] = '0;
            in_rkey[g]  = '0;
        end
        build_sbox();
        repeat (3) @(negedge clk);
        rst = '0;
        @(negedge clk);
        fork
            run_all(0);
            run_all(1);
            run_all(2);
        join
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
